fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM and feeds the decode stage.
- Holds the program counter and drives the byte address into the ROM.
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Handles hazard stalls, branch/jump redirects and flush bubbles.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and ROM address.
- INSTR_WIDTH, 32, width of the instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_f  in  1  hazard unit: hold PC and IF/ID contents
- flush_d  in  1  hazard unit: replace IF/ID with a bubble next edge
- redirect_valid  in  1  execute stage: taken branch/jump this cycle
- redirect_target  in  ADDRESS_WIDTH  next PC when redirect_valid
- imem_addr  out  ADDRESS_WIDTH  byte address to instruction ROM (= pc_f)
- imem_instr  in  INSTR_WIDTH  word returned combinationally by ROM for imem_addr
- pc_f  out  ADDRESS_WIDTH  current fetch PC
- instr_d  out  INSTR_WIDTH  IF/ID instruction
- pc_d  out  ADDRESS_WIDTH  IF/ID PC
- pc_plus4_d  out  ADDRESS_WIDTH  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- misalign_d  out  1  IF/ID PC had pc[1:0]!=0

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- ROM read is combinational, so fetch latency is 1 cycle: the word addressed in cycle N appears on instr_d after edge N+1.
- imem_addr = pc_f at all times, driven combinationally from the PC register.
- pc_plus4 = pc_f + 4, computed modulo 2^ADDRESS_WIDTH. Wrap-around from 32'hFFFF_FFFC gives 0; no trap is raised.

Reset (rst=1 at an edge):
- pc_f becomes RESET_PC.
- instr_d becomes NOP_INSTR; pc_d and pc_plus4_d become 0.
- valid_d and misalign_d become 0.
- Reset overrides every other input, including a mid-stall or mid-redirect.

PC update, priority high to low:
1. rst
2. redirect_valid -> redirect_target
3. stall_f -> hold
4. otherwise -> pc_f + 4

- A redirect wins over a simultaneous stall: a taken branch always retires the wrong-path fetch.

IF/ID update, priority high to low:
1. rst -> reset values
2. flush_d OR redirect_valid -> bubble: instr_d=NOP_INSTR, valid_d=0, misalign_d=0, pc_d/pc_plus4_d hold previous values
3. stall_f -> hold all IF/ID fields
4. otherwise -> instr_d=imem_instr, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1, misalign_d=(pc_f[1:0]!=0)

Further rules:
- flush_d and stall_f both high: flush wins. Decode sees a bubble while the PC holds.
- A misaligned redirect_target is accepted as-is. The ROM is not masked; misalign_d flags the instruction and decode/trap logic decides what to do with it.
- Internal state machine, 2 states:
  - RESET_FILL: entered on rst; valid_d=0; leaves after the first non-stalled edge.
  - RUN.
  - The state only gates valid_d. It prevents a reset-cycle ROM read of an undefined PC from being marked valid.
- No combinational path from any input to any output, except imem_addr from the PC register.

Decomposition:
- Shared package `rv_pkg`: RESET_PC and NOP_INSTR constants, plus an `if_id_t` packed struct {instr, pc, pc_plus4, valid, misalign}. Decode uses the same struct.
- One natural sub-module: `pc_reg`, containing the PC register, next-PC mux and +4 adder.
- The IF/ID register stays in `fetch_stage`.

Test Plan:
- Reset then 4 free-running cycles, ROM preloaded with words W0..W3 at 0,4,8,12 -> pc_f 0,4,8,12,16; instr_d W0..W3 with pc_d 0..12; valid_d=0 only in the first cycle after reset.
- stall_f high for 2 cycles while pc_f=8 -> pc_f stays 8; instr_d holds W1/pc_d=4 for both cycles; fetch resumes at 12 afterwards.
- redirect_valid with target 32'h40 while pc_f=12 -> next pc_f=0x40; IF/ID bubble (instr_d=0x13, valid_d=0); the following cycle instr_d=word@0x40, pc_d=0x40.
- Simultaneous stall_f=1, redirect_valid=1 (target 0x20) -> pc_f=0x20, IF/ID bubble; simultaneous flush_d=1, stall_f=1 -> pc holds, IF/ID bubble.
- Redirect to 0x22 -> misalign_d=1, pc_d=0x22 one cycle later; pc_f=0xFFFF_FFFC free-running -> wraps to 0.
- rst asserted mid-stall with pc_f=0x30 -> next edge pc_f=RESET_PC, valid_d=0, instr_d=0x13.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch and decode stages.
//   RESET_PC / NOP_INSTR : reset PC and the bubble instruction (addi x0,x0,0)
//   if_id_t              : IF/ID pipeline register contents, also read by decode
//   fetch_state_e        : fetch-stage fill tracking states
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            misalign;
    } if_id_t;

    typedef enum logic {
        RESET_FILL = 1'b0,
        RUN        = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection and +4 adder.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall_f           : hold the PC
//   redirect_valid    : load redirect_target (wins over stall_f)
//   redirect_target   : branch/jump target, accepted even if misaligned
//   pc_f              : current fetch PC (registered)
//   pc_plus4_f        : pc_f + 4, wraps modulo 2^ADDRESS_WIDTH
module pc_reg
    import rv_pkg::*;
#(
    parameter int unsigned            ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VALUE = RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f
);

    logic [ADDRESS_WIDTH-1:0] pc_f_q;
    logic [ADDRESS_WIDTH-1:0] pc_f_d;

    assign pc_plus4_f = pc_f_q + ADDRESS_WIDTH'(4);
    assign pc_f       = pc_f_q;

    always_comb begin
        pc_f_d = pc_plus4_f;
        if (redirect_valid) begin
            pc_f_d = redirect_target;
        end else if (stall_f) begin
            pc_f_d = pc_f_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q <= RESET_VALUE;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction ROM and captures the returned word into the IF/ID register.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   stall_f                           : hold PC and IF/ID
//   flush_d                           : bubble into IF/ID next edge
//   redirect_valid, redirect_target   : taken branch/jump from execute
//   imem_addr, imem_instr             : ROM address (= pc_f) and returned word
//   pc_f                              : current fetch PC
//   instr_d, pc_d, pc_plus4_d,
//   valid_d, misalign_d               : IF/ID register outputs
//
// State table:
//   state      | meaning
//   RESET_FILL | IF/ID has not captured a real fetch since reset; valid_d forced 0
//   RUN        | normal operation
module fetch_stage
    import rv_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC_P    = RESET_PC,
    parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR_P   = NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic                     flush_d,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [INSTR_WIDTH-1:0]   imem_instr,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [INSTR_WIDTH-1:0]   instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d,
    output logic                     misalign_d
);

    logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
    if_id_t                   if_id_q;
    if_id_t                   if_id_d;
    fetch_state_e             state_q;
    fetch_state_e             state_d;

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_VALUE   (RESET_PC_P)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .stall_f         (stall_f),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_f            (pc_f),
        .pc_plus4_f      (pc_plus4_f)
    );

    assign imem_addr = pc_f;

    always_comb begin
        if_id_d = if_id_q;
        state_d = state_q;

        // A redirect kills the wrong-path word being fetched this cycle;
        // pc/pc_plus4 are left alone so decode keeps a stable PC on bubbles.
        if (flush_d || redirect_valid) begin
            if_id_d.instr    = NOP_INSTR_P;
            if_id_d.valid    = 1'b0;
            if_id_d.misalign = 1'b0;
        end else if (!stall_f) begin
            if_id_d.instr    = imem_instr;
            if_id_d.pc       = pc_f;
            if_id_d.pc_plus4 = pc_plus4_f;
            if_id_d.valid    = 1'b1;
            if_id_d.misalign = (pc_f[1:0] != 2'b00);
        end

        if (redirect_valid || !stall_f) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q.instr    <= NOP_INSTR_P;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.valid    <= 1'b0;
            if_id_q.misalign <= 1'b0;
            state_q          <= RESET_FILL;
        end else begin
            if_id_q <= if_id_d;
            state_q <= state_d;
        end
    end

    assign instr_d    = if_id_q.instr;
    assign pc_d       = if_id_q.pc;
    assign pc_plus4_d = if_id_q.pc_plus4;
    assign valid_d    = if_id_q.valid && (state_q == RUN);
    assign misalign_d = if_id_q.misalign;

endmodule
